// File: rtl/bpu_gshare_btb.sv
// Branch prediction unit: gshare/bimodal PHT of saturating counters plus a direct-mapped tagged BTB.
// Lookup is combinational from the fetch PC; training arrives from EX and lands on the next posedge.
module bpu_gshare_btb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned GHR_W     = 4,
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned BTB_IDX_W = 4,
  parameter int unsigned MODE      = 1,
  localparam int unsigned GHR_PW   = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_is_jal,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispred,
  output logic [GHR_PW-1:0] ghr,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispreds
);

  localparam int unsigned PHT_N = 1 << PHT_IDX_W;
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W = XLEN - BTB_IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]  pht_q     [PHT_N];
  logic              btb_v_q   [BTB_N];
  logic [TAG_W-1:0]  btb_tag_q [BTB_N];
  logic [XLEN-1:0]   btb_tgt_q [BTB_N];
  logic              btb_u_q   [BTB_N];

  logic [GHR_PW-1:0] ghr_q, ghr_d;
  logic [31:0]       br_q, br_d;
  logic [31:0]       mis_q, mis_d;

  logic [PHT_IDX_W-1:0] ghr_x;
  logic [PHT_IDX_W-1:0] l_pidx, u_pidx;
  logic [BTB_IDX_W-1:0] l_bidx, u_bidx;
  logic [TAG_W-1:0]     l_tag, u_tag;
  logic                 l_hit;
  logic                 pht_we, btb_we;
  logic [CNT_W-1:0]     cnt_old, cnt_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // History folded into the PHT index; bimodal or zero-length history contributes nothing
  always_comb begin
    ghr_x = '0;
    if (MODE != 0 && GHR_W > 0) ghr_x = PHT_IDX_W'(ghr_q);
  end

  // Fetch-side lookup, reads pre-update state so a same-cycle update is not visible
  always_comb begin
    l_pidx      = if_pc[PHT_IDX_W+1:2] ^ ghr_x;
    l_bidx      = if_pc[BTB_IDX_W+1:2];
    l_tag       = if_pc[XLEN-1:BTB_IDX_W+2];
    l_hit       = btb_v_q[l_bidx] && (btb_tag_q[l_bidx] == l_tag);
    pred_taken  = l_hit && (btb_u_q[l_bidx] || pht_q[l_pidx][CNT_W-1]);
    pred_target = l_hit ? btb_tgt_q[l_bidx] : '0;
  end

  // EX-side training: counter step, history shift and saturating statistics
  always_comb begin
    u_pidx  = upd_pc[PHT_IDX_W+1:2] ^ ghr_x;
    u_bidx  = upd_pc[BTB_IDX_W+1:2];
    u_tag   = upd_pc[XLEN-1:BTB_IDX_W+2];
    pht_we  = upd_valid && upd_is_branch;
    btb_we  = upd_valid && upd_taken && (upd_is_branch || upd_is_jal);
    cnt_old = pht_q[u_pidx];
    cnt_d   = cnt_old;
    ghr_d   = ghr_q;
    br_d    = br_q;
    mis_d   = mis_q;
    if (pht_we) begin
      if (upd_taken && cnt_old != CNT_MAX)      cnt_d = cnt_old + CNT_W'(1);
      else if (!upd_taken && cnt_old != '0)     cnt_d = cnt_old - CNT_W'(1);
      if (GHR_W > 0) ghr_d = (ghr_q << 1) | GHR_PW'(upd_taken);
      if (br_q != '1) br_d = br_q + 32'd1;
    end
    if (upd_valid && upd_mispred && mis_q != '1) mis_d = mis_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht_q[i] <= CNT_INIT;
      for (int unsigned i = 0; i < BTB_N; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_u_q[i]   <= 1'b0;
      end
      ghr_q <= '0;
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (pht_we) pht_q[u_pidx] <= cnt_d;
      if (btb_we) begin
        btb_v_q[u_bidx]   <= 1'b1;
        btb_tag_q[u_bidx] <= u_tag;
        btb_tgt_q[u_bidx] <= upd_target;
        btb_u_q[u_bidx]   <= upd_is_jal;
      end
      ghr_q <= ghr_d;
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

  assign ghr           = ghr_q;
  assign stat_branches = br_q;
  assign stat_mispreds = mis_q;

endmodule
